mem_bus_arbiter: RTL

Two-master arbiter and sequencer for the shared 16-bit memory bus: the `wram` and the memory-mapped LED register.
- Master 0 is the processor core; master 1 is a DMA/loader port used to preload programs and read back results.
- The block grants the bus round-robin, issues each access, and decodes the region from `addr[15:12]`.
- It times the synchronous RAM read latency and returns read data with a one-cycle valid strobe.
- It sits between the masters and the existing RAM/LED register, replacing the direct processor-to-memory wiring.

---
 rtl/mem_bus_pkg.sv | 34 +++
 rtl/mem_bus_arbiter_if.sv | 31 +++
 rtl/mem_region_decode.sv | 16 +
 rtl/mem_bus_arbiter.sv | 129 ++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared definitions for the two-master memory bus.
// Contents: bus widths, region codes, master ids, FSM state and region
// encodings, and the packed request payload presented by each master.
package mem_bus_pkg;

  localparam int unsigned AW    = 16;
  localparam int unsigned DW    = 16;
  localparam int unsigned CNT_W = 2;

  localparam logic [3:0] REGION_RAM = 4'h0;
  localparam logic [3:0] REGION_LED = 4'h1;

  localparam logic M_CPU = 1'b0;
  localparam logic M_DMA = 1'b1;

  typedef enum logic {
    IDLE,
    READ
  } state_e;

  typedef enum logic [1:0] {
    RGN_RAM,
    RGN_LED,
    RGN_NONE
  } region_e;

  // Access request as presented by one master while req is high.
  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } bus_req_t;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: bundles both master ports and the RAM/LED side.
// Modports: slave = arbiter view, master = masters + memory view.
interface mem_bus_arbiter_if;
  import mem_bus_pkg::*;

  logic          m0_req,    m1_req;
  logic          m0_wr,     m1_wr;
  logic [AW-1:0] m0_addr,   m1_addr;
  logic [DW-1:0] m0_wdata,  m1_wdata;
  logic          m0_gnt,    m1_gnt;
  logic          m0_rvalid, m1_rvalid;
  logic [DW-1:0] m0_rdata,  m1_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          mem_wren;
  logic          led_wren;
  logic [DW-1:0] mem_q;

  modport slave (
    input  m0_req, m1_req, m0_wr, m1_wr, m0_addr, m1_addr, m0_wdata, m1_wdata, mem_q,
    output m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
           mem_addr, mem_data, mem_wren, led_wren
  );

  modport master (
    output m0_req, m1_req, m0_wr, m1_wr, m0_addr, m1_addr, m0_wdata, m1_wdata, mem_q,
    input  m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
           mem_addr, mem_data, mem_wren, led_wren
  );

endinterface

// File: rtl/mem_region_decode.sv
// mem_region_decode: maps the top address nibble to RAM, LED or unmapped.
// Ports: region_bits = addr[15:12]; ram/led/unmapped = one-hot region flags.
module mem_region_decode
  import mem_bus_pkg::*;
(
  input  logic [3:0] region_bits,
  output logic       ram,
  output logic       led,
  output logic       unmapped
);

  assign ram      = (region_bits == REGION_RAM);
  assign led      = (region_bits == REGION_LED);
  assign unmapped = !(ram || led);

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin arbiter and sequencer for the shared memory bus.
// Ports: Clock, Clear (async, active-high), bus (slave view of
// mem_bus_arbiter_if carrying both masters and the RAM/LED side).
// RD_LAT (1..3) is the RAM read latency in cycles.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input  logic               Clock,
  input  logic               Clear,
  mem_bus_arbiter_if.slave   bus
);

  state_e           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             last, last_n;
  logic [AW-1:0]    lat_addr, lat_addr_n;
  logic             lat_id, lat_id_n;
  region_e          lat_rgn, lat_rgn_n;

  bus_req_t         r0, r1, win;
  logic             win_id;
  logic             dec_ram, dec_led, dec_unm;
  region_e          win_rgn;
  logic             rd_done;
  logic [DW-1:0]    rd_data;

  assign r0 = '{wr: bus.m0_wr, addr: bus.m0_addr, wdata: bus.m0_wdata};
  assign r1 = '{wr: bus.m1_wr, addr: bus.m1_addr, wdata: bus.m1_wdata};

  // Winner: the lone requester, or the master not granted last time.
  always_comb begin
    win_id = M_CPU;
    if (bus.m0_req && bus.m1_req) win_id = ~last;
    else if (bus.m1_req)          win_id = M_DMA;
  end

  assign win = (win_id == M_DMA) ? r1 : r0;

  mem_region_decode u_decode (
    .region_bits (win.addr[AW-1 -: 4]),
    .ram         (dec_ram),
    .led         (dec_led),
    .unmapped    (dec_unm)
  );

  assign win_rgn = dec_unm ? RGN_NONE : (dec_led ? RGN_LED : RGN_RAM);

  // LED is write-only; only RAM reads return data.
  assign rd_data = (lat_rgn == RGN_RAM) ? bus.mem_q : '0;
  assign rd_done = (state == READ) && (cnt == '0);

  // State register.
  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      state    <= IDLE;
      cnt      <= '0;
      last     <= 1'b1;
      lat_addr <= '0;
      lat_id   <= M_CPU;
      lat_rgn  <= RGN_RAM;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      last     <= last_n;
      lat_addr <= lat_addr_n;
      lat_id   <= lat_id_n;
      lat_rgn  <= lat_rgn_n;
    end
  end

  // Next state and bus outputs; a grant may overlap the final READ cycle.
  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    last_n        = last;
    lat_addr_n    = lat_addr;
    lat_id_n      = lat_id;
    lat_rgn_n     = lat_rgn;
    bus.m0_gnt    = 1'b0;
    bus.m1_gnt    = 1'b0;
    bus.m0_rvalid = 1'b0;
    bus.m1_rvalid = 1'b0;
    bus.m0_rdata  = '0;
    bus.m1_rdata  = '0;
    bus.mem_addr  = '0;
    bus.mem_data  = '0;
    bus.mem_wren  = 1'b0;
    bus.led_wren  = 1'b0;

    if (state == READ) begin
      bus.mem_addr = lat_addr;
      if (rd_done) begin
        state_n = IDLE;
        if (lat_id == M_CPU) begin
          bus.m0_rvalid = 1'b1;
          bus.m0_rdata  = rd_data;
        end else begin
          bus.m1_rvalid = 1'b1;
          bus.m1_rdata  = rd_data;
        end
      end else begin
        cnt_n = cnt - CNT_W'(1);
      end
    end

    // Clear holds every strobe low even if a master is requesting.
    if (!Clear && (state == IDLE || rd_done) && (bus.m0_req || bus.m1_req)) begin
      if (win_id == M_CPU) bus.m0_gnt = 1'b1;
      else                 bus.m1_gnt = 1'b1;
      bus.mem_addr = win.addr;
      bus.mem_data = win.wdata;
      last_n       = win_id;
      lat_addr_n   = win.addr;
      lat_id_n     = win_id;
      lat_rgn_n    = win_rgn;
      if (win.wr) begin
        bus.mem_wren = dec_ram;
        bus.led_wren = dec_led;
        state_n      = IDLE;
      end else begin
        state_n = READ;
        cnt_n   = CNT_W'(RD_LAT - 1);
      end
    end
  end

endmodule
